// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - opcode encodings, stall FSM states and helpers for fwd_hazard_unit
package fwd_hazard_unit_pkg;

  // RV32I major opcodes seen by the EX stage
  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_IMM   = 7'b0010011;
  localparam logic [6:0] I_LOAD  = 7'b0000011;
  localparam logic [6:0] I_JALR  = 7'b1100111;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] J_JAL   = 7'b1101111;
  localparam logic [6:0] U_LUI   = 7'b0110111;
  localparam logic [6:0] U_AUIPC = 7'b0010111;

  // Width of the load-use hold down-counter
  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    FWD_IDLE = 1'b0,
    FWD_HOLD = 1'b1
  } fwd_state_e;

  // Opcodes whose operand1 comes from rs1
  function automatic logic op_fwd_rs1(input logic [6:0] op);
    return (op == R_TYPE) || (op == B_TYPE) || (op == I_IMM) ||
           (op == I_LOAD) || (op == I_JALR) || (op == S_TYPE);
  endfunction

  // Opcodes whose operand2 comes from rs2 (others carry an immediate there)
  function automatic logic op_fwd_rs2_alu(input logic [6:0] op);
    return (op == R_TYPE) || (op == B_TYPE);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID/EX/forwarding bus between the pipeline and fwd_hazard_unit
interface fwd_hazard_unit_if #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int NUM_FWD = 2
);
  logic                    isForw_ON;
  logic                    flush;
  logic                    id_valid;
  logic [RA_W-1:0]         id_rs1;
  logic [RA_W-1:0]         id_rs2;
  logic                    id_use_rs1;
  logic                    id_use_rs2;
  logic                    ex_regwrite;
  logic                    ex_is_load;
  logic [RA_W-1:0]         ex_rd;
  logic [6:0]              ex_op;
  logic [RA_W-1:0]         ex_rs1;
  logic [RA_W-1:0]         ex_rs2;
  logic [XLEN-1:0]         ex_data1;
  logic [XLEN-1:0]         ex_data2;
  logic [XLEN-1:0]         ex_sdata;
  logic [NUM_FWD-1:0]      fw_regwrite;
  logic [NUM_FWD*RA_W-1:0] fw_rd;
  logic [NUM_FWD*XLEN-1:0] fw_result;
  logic [XLEN-1:0]         operand1;
  logic [XLEN-1:0]         operand2;
  logic [XLEN-1:0]         sData;
  logic                    stall;
  logic                    bubble;
  logic [31:0]             fwd_cnt;
  logic [31:0]             stall_cnt;

  // Pipeline side: drives decode/execute state, consumes operands and stall control
  modport master (
    output isForw_ON, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_regwrite, ex_is_load, ex_rd, ex_op, ex_rs1, ex_rs2,
           ex_data1, ex_data2, ex_sdata, fw_regwrite, fw_rd, fw_result,
    input  operand1, operand2, sData, stall, bubble, fwd_cnt, stall_cnt
  );

  // Hazard unit side
  modport slave (
    input  isForw_ON, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_regwrite, ex_is_load, ex_rd, ex_op, ex_rs1, ex_rs2,
           ex_data1, ex_data2, ex_sdata, fw_regwrite, fw_rd, fw_result,
    output operand1, operand2, sData, stall, bubble, fwd_cnt, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// rtl/fwd_hazard_unit_fwd_sel.sv - priority match of one source register over the forwarding stages
module fwd_hazard_unit_fwd_sel #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [RA_W-1:0]         rs,
  input  logic [NUM_FWD-1:0]      fw_regwrite,
  input  logic [NUM_FWD*RA_W-1:0] fw_rd,
  input  logic [NUM_FWD*XLEN-1:0] fw_result,
  output logic                    hit,
  output logic [XLEN-1:0]         value
);

  // Walk oldest to youngest so the lowest-index (youngest) match overrides; x0 never matches
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fw_regwrite[i] && (fw_rd[i*RA_W +: RA_W] == rs) && (rs != '0)) begin
        hit   = 1'b1;
        value = fw_result[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding and ID load-use stall control; FWD_PERF_CNT_EN adds perf counters
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  fwd_hazard_unit_if.slave bus
);

  logic            hit1, hit2;
  logic [XLEN-1:0] val1, val2;
  logic            fwd_op1, fwd_op2, fwd_sd;
  logic            rs1_cand, rs2_cand;
  logic            lu1, lu2, load_use;
  logic            raw1, raw2, raw_hazard;
  logic            hold_stall;
  logic            stall_int;
  fwd_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  fwd_hazard_unit_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_sel_rs1 (
    .rs          (bus.ex_rs1),
    .fw_regwrite (bus.fw_regwrite),
    .fw_rd       (bus.fw_rd),
    .fw_result   (bus.fw_result),
    .hit         (hit1),
    .value       (val1)
  );

  fwd_hazard_unit_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_sel_rs2 (
    .rs          (bus.ex_rs2),
    .fw_regwrite (bus.fw_regwrite),
    .fw_rd       (bus.fw_rd),
    .fw_result   (bus.fw_result),
    .hit         (hit2),
    .value       (val2)
  );

  // Operand mux: pass-through unless forwarding is on and the opcode really reads the register
  always_comb begin
    fwd_op1 = 1'b0;
    fwd_op2 = 1'b0;
    fwd_sd  = 1'b0;
    if (bus.isForw_ON) begin
      fwd_op1 = hit1 && op_fwd_rs1(bus.ex_op);
      fwd_op2 = hit2 && op_fwd_rs2_alu(bus.ex_op);
      fwd_sd  = hit2 && (bus.ex_op == S_TYPE);
    end
  end

  assign bus.operand1 = fwd_op1 ? val1 : bus.ex_data1;
  assign bus.operand2 = fwd_op2 ? val2 : bus.ex_data2;
  assign bus.sData    = fwd_sd  ? val2 : bus.ex_sdata;

  assign rs1_cand = bus.id_valid && bus.id_use_rs1 && (bus.id_rs1 != '0);
  assign rs2_cand = bus.id_valid && bus.id_use_rs2 && (bus.id_rs2 != '0);

  assign lu1      = bus.ex_is_load && bus.ex_regwrite && (bus.ex_rd == bus.id_rs1);
  assign lu2      = bus.ex_is_load && bus.ex_regwrite && (bus.ex_rd == bus.id_rs2);
  assign load_use = bus.isForw_ON && ((rs1_cand && lu1) || (rs2_cand && lu2));

  // Without forwarding, any in-flight writer of an ID source is a hazard
  always_comb begin
    raw1 = bus.ex_regwrite && (bus.ex_rd == bus.id_rs1);
    raw2 = bus.ex_regwrite && (bus.ex_rd == bus.id_rs2);
    for (int i = 0; i < NUM_FWD; i++) begin
      if (bus.fw_regwrite[i] && (bus.fw_rd[i*RA_W +: RA_W] == bus.id_rs1)) raw1 = 1'b1;
      if (bus.fw_regwrite[i] && (bus.fw_rd[i*RA_W +: RA_W] == bus.id_rs2)) raw2 = 1'b1;
    end
  end

  assign raw_hazard = !bus.isForw_ON && ((rs1_cand && raw1) || (rs2_cand && raw2));

  // Stall FSM state and hold counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FWD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: a load-use hit stalls immediately and holds for the remaining LOAD_LAT-1 cycles
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hold_stall = 1'b0;
    case (state)
      FWD_IDLE: begin
        if (!bus.flush && load_use) begin
          hold_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nx = FWD_HOLD;
            cnt_nx   = CNT_W'(LOAD_LAT - 1);
          end
        end
      end
      FWD_HOLD: begin
        if (bus.flush) begin
          state_nx = FWD_IDLE;
          cnt_nx   = '0;
        end else begin
          hold_stall = 1'b1;
          cnt_nx     = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = FWD_IDLE;
        end
      end
      default: begin
        state_nx = FWD_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Flush wins over every stall source
  assign stall_int  = !bus.flush && (hold_stall || raw_hazard);
  assign bus.stall  = stall_int;
  assign bus.bubble = stall_int;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] fwd_cnt_q, stall_cnt_q;

  // Event counters, free-running and wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fwd_op1 || fwd_op2 || fwd_sd) fwd_cnt_q <= fwd_cnt_q + 32'd1;
      if (stall_int) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.fwd_cnt   = fwd_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.fwd_cnt   = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule
